stream_pattern_gen: RTL and testbench
=====================================

Name: stream_pattern_gen

Overview:
Parametrised, synthesizable stimulus source that emits programmable data patterns over a valid/ready stream. It replaces ad-hoc testbench data incrementers with a reusable generator supporting multiple interleaved channels, several pattern modes, burst length, backpressure and abort. It sits between test/config logic and any DUT stream input.

Parameters:
DATA_W, 8, data width in bits (2..64)
NUM_CH, 1, number of round-robin interleaved channels (1..16)
CH_W, $clog2(NUM_CH) min 1, channel id width
LEN_W, 16, burst length counter width
LFSR_TAPS, 8'hB8, Galois feedback mask, DATA_W bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin burst; sampled in IDLE only
abort  in  1  terminate burst
mode  in  2  0 INC, 1 CONST, 2 LFSR, 3 WALK1
seed  in  DATA_W  base value
step  in  DATA_W  INC increment
burst_len  in  LEN_W  total beats in burst
out_valid  out  1  beat valid
out_ready  in  1  sink ready
out_data  out  DATA_W  beat data
out_ch  out  CH_W  channel of this beat
out_last  out  1  final beat of burst
busy  out  1  high in RUN
done  out  1  one-cycle pulse at burst end
stat_beats  out  LEN_W  beats transferred (optional feature)
stat_stalls  out  LEN_W  stall cycles (optional feature)

Behaviour:
- One clock; reset asynchronous, active-low. On reset: IDLE; out_valid, out_last, busy, done = 0; out_data, out_ch = 0; all lane registers and counters = 0.
- FSM: IDLE -> RUN on start with burst_len != 0. IDLE -> IDLE with done = 1 next cycle on start with burst_len == 0. RUN -> IDLE after the last beat transfers or on abort.
- mode, seed, step and burst_len are latched at start. Changes during RUN are ignored. start during RUN is ignored.
- Latency: start sampled at edge N gives out_valid = 1 from edge N+1.
- Transfer occurs when out_valid && out_ready. While out_valid && !out_ready, out_data, out_ch and out_last hold stable.
- Beat n (0-based) belongs to channel n mod NUM_CH. out_ch wraps from NUM_CH-1 to 0.
- Each channel lane holds its own value. Initial value is seed + c (mod 2^DATA_W). In LFSR and WALK1 modes, an initial value of 0 is replaced by 1. A lane advances only when its beat transfers.
- Next-value rules:
  - INC: v + step, wraps mod 2^DATA_W.
  - CONST: v.
  - LFSR: if v[0], (v >> 1) ^ LFSR_TAPS; else v >> 1.
  - WALK1: rotate left by 1.
- out_last = 1 on beat burst_len-1.
- done pulses the cycle after the last transfer. busy = 1 exactly in RUN.
- abort in RUN: out_valid drops the next cycle, even mid-stall (a deliberate exception to stability). FSM goes to IDLE, done pulses, and out_last is not asserted. If abort and the final transfer occur in the same cycle, the transfer counts and the burst completes normally. abort in IDLE has no effect.
- Reset mid-burst clears everything immediately. No done pulse.

Optional Feature:
Macro STREAM_PATTERN_GEN_STATS_EN.
- Defined: stat_beats counts transfers and stat_stalls counts out_valid && !out_ready cycles. Both clear at start, saturate at all-ones, and hold after the burst.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Decomposition:
- Package stream_gen_pkg: mode_e enum (INC, CONST, LFSR, WALK1), state_e enum (IDLE, RUN), default LFSR_TAPS constant, function next_value(mode, v, step, taps).
- Sub-module stream_gen_lane: one per channel, instantiated via generate. Holds the lane register; inputs are init, load and advance.

Test Plan:
- DATA_W=8, NUM_CH=1, INC, seed 0, step 1, len 10, ready=1 -> data 0..9 on consecutive cycles; last on 9; done on the next cycle.
- Same config with ready low on beats 3-5 for 2 cycles each -> data/last stable while stalled; sequence unchanged; stat_stalls = 6 with the macro.
- INC, seed 8'hFE, step 1, len 4 -> FE, FF, 00, 01 (wrap).
- NUM_CH=2, INC, seed 10, step 5, len 4 -> (ch0,10), (ch1,11), (ch0,15), (ch1,16).
- LFSR, seed 1, taps B8, len 4 -> 01, B8, 5C, 2E. WALK1, seed 0, len 3 -> 01, 02, 04.
- abort at beat 2 of len 8 -> valid low the next cycle, no last, done pulse, busy 0. Then len 0 start -> no valid; done after 1 cycle.

Source files
------------

// File: rtl/stream_gen_pkg.sv
// Shared types and helpers for the stream pattern generator.
package stream_gen_pkg;

  typedef enum logic [1:0] {
    ModeInc   = 2'd0,
    ModeConst = 2'd1,
    ModeLfsr  = 2'd2,
    ModeWalk1 = 2'd3
  } mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Galois feedback mask for an 8-bit maximal-length LFSR; wider widths override it.
  localparam logic [63:0] LfsrTapsDefault = 64'hB8;

  // Next lane value, computed at 64 bits and masked down to the live width.
  function automatic logic [63:0] next_value(mode_e mode, logic [63:0] v, logic [63:0] step,
                                             logic [63:0] taps, int unsigned width);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    case (mode)
      ModeInc:   r = v + step;
      ModeConst: r = v;
      ModeLfsr:  r = v[0] ? ((v >> 1) ^ taps) : (v >> 1);
      ModeWalk1: r = (v << 1) | (v >> (width - 1));
      default:   r = v;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/stream_gen_lane.sv
// One channel lane: holds its running pattern value, loads at burst start and
// advances only when a beat of this channel transfers.
module stream_gen_lane
  import stream_gen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = LfsrTapsDefault[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] init,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] value_q, value_d;

  // Load takes priority; otherwise step the pattern on a transfer.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = init;
    end else if (advance) begin
      value_d = DATA_W'(next_value(mode, 64'(value_q), 64'(step), 64'(LFSR_TAPS), DATA_W));
    end
  end

  // Lane value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/stream_pattern_gen.sv
// Programmable pattern source on a valid/ready stream with round-robin channels,
// burst length, backpressure and abort.
// Optional transfer/stall statistics: define STREAM_PATTERN_GEN_STATS_EN.
module stream_pattern_gen
  import stream_gen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_CH    = 1,
  parameter int unsigned       CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned       LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = LfsrTapsDefault[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] step,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  stat_beats,
  output logic [LEN_W-1:0]  stat_stalls
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              done_q, done_d;

  logic              fire;
  logic              is_last;
  logic              lane_load;
  logic [NUM_CH-1:0] lane_adv;
  logic [DATA_W-1:0] lane_init [NUM_CH];
  logic [DATA_W-1:0] lane_val  [NUM_CH];

  assign out_valid = (state_q == StRun);
  assign fire      = out_valid && out_ready;
  assign is_last   = (beat_q == (len_q - LEN_W'(1)));
  assign out_last  = out_valid && is_last;
  assign busy      = out_valid;
  assign done      = done_q;
  assign out_ch    = ch_q;

  // Per-lane start value from the live inputs; zero would lock LFSR/WALK1, so force 1.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lane_init[c] = seed + DATA_W'(c);
      if ((mode_e'(mode) == ModeLfsr || mode_e'(mode) == ModeWalk1) && lane_init[c] == '0) begin
        lane_init[c] = DATA_W'(1);
      end
    end
  end

  // Route the transfer to the lane owning the current beat and select its value.
  always_comb begin
    out_data = '0;
    lane_adv = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        out_data    = lane_val[c];
        lane_adv[c] = fire;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    stream_gen_lane #(
      .DATA_W    (DATA_W),
      .LFSR_TAPS (LFSR_TAPS)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode    (mode_q),
      .step    (step_q),
      .init    (lane_init[c]),
      .load    (lane_load),
      .advance (lane_adv[c]),
      .value   (lane_val[c])
    );
  end

  // Burst control: latch config at start, count beats, end on last transfer or abort.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    step_d    = step_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ch_d      = ch_q;
    done_d    = 1'b0;
    lane_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (burst_len != '0) begin
            state_d   = StRun;
            mode_d    = mode_e'(mode);
            step_d    = step;
            len_d     = burst_len;
            beat_d    = '0;
            ch_d      = '0;
            lane_load = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (fire) begin
          beat_d = beat_q + LEN_W'(1);
          ch_d   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
        end
        // A final transfer coinciding with abort completes normally either way.
        if ((fire && is_last) || abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeInc;
      step_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ch_q    <= ch_d;
      done_q  <= done_d;
    end
  end

`ifdef STREAM_PATTERN_GEN_STATS_EN
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [LEN_W-1:0] stalls_q, stalls_d;
  logic             stat_clr;

  assign stat_clr = (state_q == StIdle) && start;

  // Saturating counters, cleared at start and frozen once the burst ends.
  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (stat_clr) begin
      beats_d  = '0;
      stalls_d = '0;
    end else begin
      if (fire && beats_q != '1) begin
        beats_d = beats_q + LEN_W'(1);
      end
      if (out_valid && !out_ready && stalls_q != '1) begin
        stalls_d = stalls_q + LEN_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench: table of burst configurations with hand-computed beats, plus
// hand-written stall, abort, zero-length and reset sequences.
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [1:0]  mode;
  logic [7:0]  seed, step;
  logic [15:0] burst_len;

  logic        v1, l1, b1, dn1, c1;
  logic [7:0]  d1;
  logic [15:0] sb1, ss1;
  logic        v2, l2, b2, dn2, c2;
  logic [7:0]  d2;
  logic [15:0] sb2, ss2;

  logic        use2;
  logic        cv, cl, cb, cdn, cc;
  logic [7:0]  cd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_pattern_gen #(.DATA_W(8), .NUM_CH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .step(step), .burst_len(burst_len), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_ch(c1), .out_last(l1), .busy(b1), .done(dn1),
    .stat_beats(sb1), .stat_stalls(ss1)
  );

  stream_pattern_gen #(.DATA_W(8), .NUM_CH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .step(step), .burst_len(burst_len), .out_valid(v2), .out_ready(out_ready),
    .out_data(d2), .out_ch(c2), .out_last(l2), .busy(b2), .done(dn2),
    .stat_beats(sb2), .stat_stalls(ss2)
  );

  assign cv  = use2 ? v2 : v1;
  assign cl  = use2 ? l2 : l1;
  assign cb  = use2 ? b2 : b1;
  assign cdn = use2 ? dn2 : dn1;
  assign cc  = use2 ? c2 : c1;
  assign cd  = use2 ? d2 : d1;

  typedef struct packed {
    logic            sel2;
    logic [1:0]      mode;
    logic [7:0]      seed;
    logic [7:0]      step;
    logic [15:0]     len;
    logic [0:7][7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_burst(input logic sel2, input logic [1:0] m, input logic [7:0] s,
                             input logic [7:0] st, input logic [15:0] len);
    @(negedge clk);
    use2 = sel2; mode = m; seed = s; step = st; burst_len = len;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    start_burst(v.sel2, v.mode, v.seed, v.step, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      chk($sformatf("v%0d valid[%0d]", k, i), 64'(cv), 64'd1);
      chk($sformatf("v%0d data[%0d]", k, i), 64'(cd), 64'(v.exp_data[i]));
      chk($sformatf("v%0d ch[%0d]", k, i), 64'(cc), v.sel2 ? 64'(i % 2) : 64'd0);
      chk($sformatf("v%0d last[%0d]", k, i), 64'(cl), 64'(i == int'(v.len) - 1));
      @(negedge clk);
    end
    chk($sformatf("v%0d done", k), 64'(cdn), 64'd1);
    chk($sformatf("v%0d valid_after", k), 64'(cv), 64'd0);
    chk($sformatf("v%0d busy_after", k), 64'(cb), 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", k), 64'(cdn), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{sel2: 1'b0, mode: 2'd0, seed: 8'hFE, step: 8'h01, len: 16'd4,
                exp_data: {8'hFE, 8'hFF, 8'h00, 8'h01, 32'h0}};
    vecs[1] = '{sel2: 1'b1, mode: 2'd0, seed: 8'd10, step: 8'd5, len: 16'd4,
                exp_data: {8'd10, 8'd11, 8'd15, 8'd16, 32'h0}};
    vecs[2] = '{sel2: 1'b0, mode: 2'd2, seed: 8'h01, step: 8'h00, len: 16'd4,
                exp_data: {8'h01, 8'hB8, 8'h5C, 8'h2E, 32'h0}};
    vecs[3] = '{sel2: 1'b0, mode: 2'd3, seed: 8'h00, step: 8'h00, len: 16'd3,
                exp_data: {8'h01, 8'h02, 8'h04, 40'h0}};
    vecs[4] = '{sel2: 1'b0, mode: 2'd1, seed: 8'h5A, step: 8'h07, len: 16'd3,
                exp_data: {8'h5A, 8'h5A, 8'h5A, 40'h0}};
    vecs[5] = '{sel2: 1'b1, mode: 2'd3, seed: 8'h00, step: 8'h00, len: 16'd4,
                exp_data: {8'h01, 8'h01, 8'h02, 8'h02, 32'h0}};
    vecs[6] = '{sel2: 1'b1, mode: 2'd2, seed: 8'hFF, step: 8'h00, len: 16'd4,
                exp_data: {8'hFF, 8'h01, 8'hC7, 8'hB8, 32'h0}};
    vecs[7] = '{sel2: 1'b0, mode: 2'd3, seed: 8'h80, step: 8'h00, len: 16'd2,
                exp_data: {8'h80, 8'h01, 48'h0}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; use2 = 1'b0;
    mode = 2'd0; seed = 8'h00; step = 8'h00; burst_len = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst valid", 64'(v1), 64'd0);
    chk("rst last", 64'(l1), 64'd0);
    chk("rst busy", 64'(b1), 64'd0);
    chk("rst done", 64'(dn1), 64'd0);
    chk("rst data", 64'(d1), 64'd0);
    chk("rst ch", 64'(c2), 64'd0);
    rst_n = 1'b1;

    // Baseline INC with stalls on beats 3..5; config changes and a second start are ignored.
    start_burst(1'b0, 2'd0, 8'h00, 8'h01, 16'd10);
    seed = 8'h55; step = 8'h03; mode = 2'd1; burst_len = 16'd3;
    for (int i = 0; i < 10; i++) begin
      start = (i == 1);
      chk($sformatf("inc valid[%0d]", i), 64'(cv), 64'd1);
      chk($sformatf("inc data[%0d]", i), 64'(cd), 64'(i));
      chk($sformatf("inc last[%0d]", i), 64'(cl), 64'(i == 9));
      if (i >= 3 && i <= 5) begin
        out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          start = 1'b0;
          chk($sformatf("stall valid[%0d]", i), 64'(cv), 64'd1);
          chk($sformatf("stall data[%0d]", i), 64'(cd), 64'(i));
          chk($sformatf("stall last[%0d]", i), 64'(cl), 64'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("inc done", 64'(cdn), 64'd1);
    chk("inc busy_after", 64'(cb), 64'd0);
`ifdef STREAM_PATTERN_GEN_STATS_EN
    chk("stat beats", 64'(sb1), 64'd10);
    chk("stat stalls", 64'(ss1), 64'd6);
`else
    chk("stat beats tied", 64'(sb1), 64'd0);
    chk("stat stalls tied", 64'(ss1), 64'd0);
`endif
    @(negedge clk);
    chk("inc done_pulse", 64'(cdn), 64'd0);
`ifdef STREAM_PATTERN_GEN_STATS_EN
    chk("stat beats hold", 64'(sb1), 64'd10);
`endif

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Abort mid-stall on beat 2 of 8.
    start_burst(1'b0, 2'd0, 8'h00, 8'h01, 16'd8);
    repeat (2) @(negedge clk);
    chk("abort data", 64'(cd), 64'd2);
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valid", 64'(cv), 64'd0);
    chk("abort last", 64'(cl), 64'd0);
    chk("abort busy", 64'(cb), 64'd0);
    chk("abort done", 64'(cdn), 64'd1);
    @(negedge clk);
    chk("abort done_pulse", 64'(cdn), 64'd0);
    out_ready = 1'b1;

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort valid", 64'(cv), 64'd0);
    chk("idle abort done", 64'(cdn), 64'd0);

    // Zero-length start: done only.
    start_burst(1'b0, 2'd0, 8'h00, 8'h01, 16'd0);
    chk("len0 valid", 64'(cv), 64'd0);
    chk("len0 busy", 64'(cb), 64'd0);
    chk("len0 done", 64'(cdn), 64'd1);
    @(negedge clk);
    chk("len0 done_pulse", 64'(cdn), 64'd0);

    // Abort coinciding with the final transfer completes the burst.
    start_burst(1'b0, 2'd0, 8'h20, 8'h01, 16'd2);
    chk("abtlast data0", 64'(cd), 64'h20);
    @(negedge clk);
    chk("abtlast data1", 64'(cd), 64'h21);
    chk("abtlast last", 64'(cl), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abtlast done", 64'(cdn), 64'd1);
    chk("abtlast valid", 64'(cv), 64'd0);
`ifdef STREAM_PATTERN_GEN_STATS_EN
    chk("abtlast beats", 64'(sb1), 64'd2);
`endif

    // Reset mid-burst clears immediately with no done.
    start_burst(1'b0, 2'd0, 8'h40, 8'h01, 16'd8);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid valid", 64'(cv), 64'd0);
    chk("rstmid busy", 64'(cb), 64'd0);
    chk("rstmid data", 64'(cd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstmid done", 64'(cdn), 64'd0);
    @(negedge clk);
    chk("rstmid done2", 64'(cdn), 64'd0);
    chk("rstmid valid2", 64'(cv), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
